display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexed scanner for a common-segment multi-digit 7-segment display.
- Holds a packed BCD word and presents one 4-bit digit code per slot on digit_data. digit_data feeds the team's BCD-to-7-segment decoder directly.
- Drives one-hot digit enables with a dead-time gap between digits to suppress ghosting.
- Blank digits are emitted as code 4'hF, which the decoder maps to all segments off.

Parameters:
- DIGITS, 4: number of display digits, legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot, at least 2.
- DEAD_CYCLES, 2: cycles at the start of each slot with all enables off. Must satisfy 0 <= DEAD_CYCLES < REFRESH_DIV.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- bcd_in, input, 4*DIGITS: packed BCD value. Digit 0 (least significant) is bits [3:0].
- load, input, 1: one-cycle strobe that captures bcd_in.
- lz_en, input, 1: leading-zero blanking enable.
- busy, output, 1: a captured value is waiting for the next frame boundary.
- digit_data, output, 4: code for the active digit; 4'hF means blank.
- digit_sel, output, DIGITS: one-hot digit enable, active-high; all zero during dead time.
- frame_start, output, 1: one-cycle pulse at the start of the digit-0 slot.

Behaviour:
- Reset (async, rst=1): cnt=0, idx=0, shadow=0, pending=0, busy=0, digit_sel=0, digit_data=4'hF, frame_start=0.
- Counters:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cnt wrap edge, idx advances modulo DIGITS. idx DIGITS-1 goes to 0.
  - The frame boundary is the edge where cnt wraps and idx goes DIGITS-1 -> 0.
- Capture:
  - load=1 latches bcd_in into pending and sets busy the next cycle.
  - If load is asserted again while busy, pending is overwritten; last write wins.
  - At a frame boundary with busy=1: shadow <= pending and busy <= 0.
  - If load=1 on the frame-boundary cycle itself: bcd_in goes straight into shadow, any older pending value is discarded, and busy=0.
  - The shadow value never changes mid-frame, so there is no tearing.
- Outputs are registered and computed from the post-edge cnt/idx/shadow:
  - digit_sel = 0 when cnt < DEAD_CYCLES. Otherwise digit_sel = 1 << idx.
  - digit_data = shadow digit idx, unless blanked. It updates on the same edge idx changes, so it is stable throughout the dead time.
  - frame_start = 1 for exactly the one cycle where cnt=0 and idx=0. This includes the first cycle after reset release, since the counters start at 0/0.
- Leading-zero blanking:
  - With lz_en=1, a digit i>0 is blanked (4'hF) if it and all shadow digits above it are 0.
  - Digit 0 is never blanked.
  - With lz_en=0, no digit is blanked.
  - lz_en is sampled every cycle; there is no frame alignment.
- Digit codes: values 10..15 in shadow are passed through unchanged. Invalid BCD is not checked.
- Reset mid-operation: all state returns to reset values immediately. Scanning restarts at idx 0 on the first edge after rst falls.
- DIGITS=1: idx stays 0, and every cnt wrap is a frame boundary.

Test Plan (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset, then release and run with no load:
  - digit_data=0 every slot; digit_sel pattern per slot is 0,0,1 x6; 0,0,2 x6; 0,0,4 x6; 0,0,8 x6; repeat.
  - frame_start high on cycle 0 and every 32 cycles thereafter.
- load bcd_in=16'h1234 mid-frame:
  - busy=1 until the next boundary; old digits are shown for the rest of the frame.
  - Next frame shows 4,3,2,1 on sel 1,2,4,8.
- lz_en=1 with 16'h0050:
  - Digit codes are 0,5,F,F.
  - With 16'h0000, codes are 0,F,F,F.
- Two loads while busy (16'h1111 then 16'h2222):
  - Only 2222 appears after the boundary.
  - load of 16'h9999 exactly on a boundary cycle is displayed that frame, busy stays 0, and any earlier pending value is dropped.
- Assert rst during slot 2 with digit_sel=4:
  - Outputs go to 0/F/0 asynchronously, shadow is cleared.
  - After release, scanning restarts at sel 1 after 2 dead cycles.
- Check continuously that digit_sel is never more than one-hot.

Source files
------------

// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a common-segment multi-digit 7-segment display.
// Emits one BCD code per slot with one-hot enables, dead time and optional leading-zero blanking.
module display_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic                  busy,
  output logic [3:0]            digit_data,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 run_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0]  shadow_q, shadow_d;
  logic [4*DIGITS-1:0]  pending_q, pending_d;
  logic                 busy_q, busy_d;
  logic [DIGITS-1:0]    sel_q, sel_d;
  logic [3:0]           data_q, data_d;
  logic                 fs_q, fs_d;
  logic                 wrap;
  logic                 boundary;

  // Code for digit i of v; blanked when lz is set, i>0 and digit i plus all above are zero.
  function automatic logic [3:0] digit_code(input logic [4*DIGITS-1:0] v,
                                            input logic [IDX_W-1:0]    i,
                                            input logic                lz);
    logic [3:0] code;
    logic       zero_above;
    code       = 4'h0;
    zero_above = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      if (j >= int'(i)) zero_above = zero_above & (v[4*j +: 4] == 4'h0);
      if (j == int'(i)) code = v[4*j +: 4];
    end
    if (lz && (i != '0) && zero_above) code = 4'hF;
    return code;
  endfunction

  always_comb begin
    wrap     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    boundary = run_q && wrap && (idx_q == IDX_W'(DIGITS - 1));

    // The first edge after reset only arms the scanner, so the 0/0 slot is visible with frame_start.
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (run_q) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    if (boundary && load) begin
      shadow_d = bcd_in;
      busy_d   = 1'b0;
    end else if (load) begin
      pending_d = bcd_in;
      busy_d    = 1'b1;
    end else if (boundary && busy_q) begin
      shadow_d = pending_q;
      busy_d   = 1'b0;
    end

    sel_d  = (int'(cnt_d) < DEAD_CYCLES) ? '0 : (DIGITS'(1) << idx_d);
    data_d = digit_code(shadow_d, idx_d, lz_en);
    fs_d   = (cnt_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
      sel_q     <= '0;
      data_q    <= 4'hF;
      fs_q      <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      fs_q      <= fs_d;
    end
  end

  assign busy        = busy_q;
  assign digit_data  = data_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_display_scan_mux;

  localparam int DIGITS = 4;
  localparam int RDIV   = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * RDIV;

  logic              clk;
  logic              rst;
  logic [15:0]       bcd_in;
  logic              load;
  logic              lz_en;
  logic              busy;
  logic [3:0]        digit_data;
  logic [3:0]        digit_sel;
  logic              frame_start;

  int                errors;
  int                checks;
  int                c;
  logic [15:0]       exp_code;
  logic              exp_busy;

  display_scan_mux #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .lz_en(lz_en),
    .busy(busy), .digit_data(digit_data), .digit_sel(digit_sel),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s c=%0d got=%h expected=%h", tag, c, got, exp);
    end
  endtask

  // Cycle c counts slots from the first post-reset edge: cnt=c%8, idx=(c/8)%4.
  task automatic tick();
    int slot;
    int ix;
    logic [3:0] es;
    @(posedge clk);
    c++;
    @(negedge clk);
    slot = c % RDIV;
    ix   = (c / RDIV) % DIGITS;
    es   = (slot < DEAD) ? 4'b0000 : 4'(1 << ix);
    check("digit_sel", 16'(digit_sel), 16'(es));
    check("frame_start", 16'(frame_start), 16'((c % FRAME) == 0));
    check("digit_data", 16'(digit_data), 16'(exp_code[4*ix +: 4]));
    check("busy", 16'(busy), 16'(exp_busy));
  endtask

  task automatic load_and_show(input logic [15:0] val, input logic [15:0] codes);
    repeat (3) tick();
    bcd_in   = val;
    load     = 1'b1;
    exp_busy = 1'b1;
    tick();
    load = 1'b0;
    while ((c % FRAME) != FRAME - 1) tick();
    exp_code = codes;
    exp_busy = 1'b0;
    tick();
    while ((c % FRAME) != FRAME - 1) tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($onehot0(digit_sel)) else begin
        errors++;
        $error("FAIL onehot c=%0d got=%b expected=at most one bit", c, digit_sel);
      end
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    c        = -1;
    rst      = 1'b1;
    load     = 1'b0;
    lz_en    = 1'b0;
    bcd_in   = 16'h0000;
    exp_code = 16'h0000;
    exp_busy = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_sel", 16'(digit_sel), 16'h0);
    check("rst_data", 16'(digit_data), 16'hF);
    check("rst_fs", 16'(frame_start), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);

    rst = 1'b0;
    c   = -1;
    repeat (2 * FRAME) tick();

    load_and_show(16'h1234, 16'h1234);

    lz_en = 1'b1;
    load_and_show(16'h0050, 16'hFF50);
    load_and_show(16'h0000, 16'hFFF0);

    lz_en    = 1'b0;
    exp_code = 16'h0000;
    tick();
    repeat (2) tick();
    bcd_in   = 16'h1111;
    load     = 1'b1;
    exp_busy = 1'b1;
    tick();
    bcd_in = 16'h2222;
    tick();
    load = 1'b0;
    while ((c % FRAME) != FRAME - 1) tick();
    exp_code = 16'h2222;
    exp_busy = 1'b0;
    tick();
    while ((c % FRAME) != FRAME - 1) tick();

    repeat (3) tick();
    bcd_in   = 16'h1111;
    load     = 1'b1;
    exp_busy = 1'b1;
    tick();
    load = 1'b0;
    while ((c % FRAME) != FRAME - 1) tick();
    bcd_in   = 16'h9999;
    load     = 1'b1;
    exp_code = 16'h9999;
    exp_busy = 1'b0;
    tick();
    load = 1'b0;
    repeat (FRAME + 4) tick();

    while ((c % FRAME) != 2 * RDIV + 4) tick();
    check("pre_rst_sel", 16'(digit_sel), 16'h4);
    rst = 1'b1;
    #1;
    check("arst_sel", 16'(digit_sel), 16'h0);
    check("arst_data", 16'(digit_data), 16'hF);
    check("arst_fs", 16'(frame_start), 16'h0);
    check("arst_busy", 16'(busy), 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    c        = -1;
    exp_code = 16'h0000;
    exp_busy = 1'b0;
    repeat (FRAME + 8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
